switch_input_port: RTL and testbench

Memory-mapped input peripheral that brings the board's 16 slide switches into the processor: synchronizes each raw switch bit, debounces it, and exposes the debounced value, sticky per-bit change flags, a change counter and an interrupt line through a small load/store register window. It is the input-side counterpart of the LED output path. It sits inside the top-level board wrapper between the `SW` pins and the processor's data-memory address decode.

---
 rtl/switch_input_port_pkg.sv | 12 +
 rtl/switch_input_port_debounce_bit.sv | 51 +++++
 rtl/switch_input_port.sv | 97 +++++++++
 tb/tb_switch_input_port.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/switch_input_port_pkg.sv
// Register map and bus-decode constants for the switch input peripheral.
package switch_input_port_pkg;

  localparam logic [1:0] SWP_VALUE = 2'd0;
  localparam logic [1:0] SWP_FLAGS = 2'd1;
  localparam logic [1:0] SWP_COUNT = 2'd2;
  localparam logic [1:0] SWP_MASK  = 2'd3;

  // Word-aligned window of four registers; decode compares addr[31:4].
  localparam logic [31:0] SWP_BASE_ADDR = 32'h0000_4010;

endpackage

// File: rtl/switch_input_port_debounce_bit.sv
// One switch bit: two-flop synchronizer, tick-counted stability filter,
// debounced level and a one-cycle change strobe.
module debounce_bit #(
  parameter int STABLE_TICKS = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic i_tick,
  input  logic i_raw,
  output logic o_deb,
  output logic o_chg
);

  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_deb;
  logic [CW-1:0] r_cnt;
  logic          w_differs;
  logic          w_accept;

  assign w_differs = (r_sync2 != r_deb);
  // Accept happens on the edge following the qualifying tick.
  assign w_accept  = w_differs && i_tick && (r_cnt == CNT_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_deb   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (!w_differs) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_deb <= r_sync2;
        r_cnt <= '0;
      end else if (i_tick) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_deb = r_deb;
  assign o_chg = w_accept;

endmodule

// File: rtl/switch_input_port.sv
// Switch input peripheral: shared debounce prescaler, per-bit debouncers and
// a four-register load/store window with sticky change flags and interrupt.
module switch_input_port
  import switch_input_port_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int TICK_CYCLES  = 100000,
  parameter int STABLE_TICKS = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic             sel,
  input  logic             rd_en,
  input  logic             wr_en,
  input  logic [1:0]       addr,
  input  logic [31:0]      wr_data,
  output logic [31:0]      rd_data,
  output logic             irq
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

  logic [PW-1:0]    r_presc;
  logic [WIDTH-1:0] r_flags;
  logic [WIDTH-1:0] r_mask;
  logic [15:0]      r_count;
  logic [31:0]      r_rd_data;
  logic             w_tick;
  logic [WIDTH-1:0] w_deb;
  logic [WIDTH-1:0] w_chg;
  logic [WIDTH-1:0] w_flag_clr;
  logic             w_rd;
  logic             w_wr;
  logic             w_unused_wr_bits;

  assign w_unused_wr_bits = &{1'b0, wr_data};
  assign w_tick = (r_presc == PRESC_LAST);
  assign w_rd   = sel && rd_en;
  assign w_wr   = sel && wr_en;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_debounce_bit (
      .clock  (clock),
      .reset  (reset),
      .i_tick (w_tick),
      .i_raw  (sw_raw[gi]),
      .o_deb  (w_deb[gi]),
      .o_chg  (w_chg[gi])
    );
  end

  assign w_flag_clr = (w_wr && (addr == SWP_FLAGS)) ? wr_data[WIDTH-1:0] : '0;

  // Set is OR-ed in after the clear so a coincident change keeps its flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_flags <= '0;
      r_mask  <= '0;
      r_count <= '0;
    end else begin
      r_flags <= (r_flags & ~w_flag_clr) | w_chg;
      r_count <= r_count + {15'd0, |w_chg};
      if (w_wr && (addr == SWP_MASK)) begin
        r_mask <= wr_data[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd_data <= '0;
    end else if (w_rd) begin
      case (addr)
        SWP_VALUE: r_rd_data <= 32'(w_deb);
        SWP_FLAGS: r_rd_data <= 32'(r_flags);
        SWP_COUNT: r_rd_data <= {16'd0, r_count};
        default:   r_rd_data <= 32'(r_mask);
      endcase
    end
  end

  assign rd_data = r_rd_data;
  assign irq     = |(r_flags & r_mask);

endmodule

// File: tb/tb_switch_input_port.sv
// Directed bench for switch_input_port with a read-data scoreboard queue.
module tb_switch_input_port;
  import switch_input_port_pkg::*;

  localparam int WIDTH = 16;

  logic             clock;
  logic             reset;
  logic [WIDTH-1:0] sw_raw;
  logic             sel;
  logic             rd_en;
  logic             wr_en;
  logic [1:0]       addr;
  logic [31:0]      wr_data;
  logic [31:0]      rd_data;
  logic             irq;

  logic             bus_valid;
  logic [31:0]      bus_addr;

  int checks;
  int failures;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  assign sel  = bus_valid && (bus_addr[31:4] == SWP_BASE_ADDR[31:4]);
  assign addr = bus_addr[3:2];

  switch_input_port #(
    .WIDTH(WIDTH),
    .TICK_CYCLES(4),
    .STABLE_TICKS(3)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .sw_raw  (sw_raw),
    .sel     (sel),
    .rd_en   (rd_en),
    .wr_en   (wr_en),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .irq     (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic rd(input logic [1:0] off, input logic [31:0] exp, input string tag);
    bus_valid = 1'b1;
    rd_en     = 1'b1;
    bus_addr  = SWP_BASE_ADDR + {28'd0, off, 2'b00};
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clock);
    #1;
    bus_valid = 1'b0;
    rd_en     = 1'b0;
    check(tag_q.pop_front(), rd_data, exp_q.pop_front());
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] d);
    bus_valid = 1'b1;
    wr_en     = 1'b1;
    bus_addr  = SWP_BASE_ADDR + {28'd0, off, 2'b00};
    wr_data   = d;
    @(posedge clock);
    #1;
    bus_valid = 1'b0;
    wr_en     = 1'b0;
  endtask

  initial begin
    int  n;
    bit  seen;
    checks    = 0;
    failures  = 0;
    bus_valid = 1'b0;
    bus_addr  = '0;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    wr_data   = '0;
    sw_raw    = 16'h000C;
    reset     = 1'b1;
    #1 reset  = 1'b0;

    // Reset state with switches 2 and 3 already on.
    idle(3);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    reset = 1'b1;
    rd(SWP_VALUE, 32'h0, "rst_value");
    rd(SWP_FLAGS, 32'h0, "rst_flags");
    rd(SWP_COUNT, 32'h0, "rst_count");
    rd(SWP_MASK,  32'h0, "rst_mask");
    idle(16);
    rd(SWP_VALUE, 32'h000C, "boot_value");
    rd(SWP_FLAGS, 32'h000C, "boot_flags");
    rd(SWP_COUNT, 32'h1,    "boot_count");
    check("boot_irq", {31'd0, irq}, 32'd0);

    // Glitch shorter than the accept window.
    sw_raw = 16'h000D;
    idle(6);
    sw_raw = 16'h000C;
    idle(20);
    rd(SWP_VALUE, 32'h000C, "glitch_value");
    rd(SWP_FLAGS, 32'h000C, "glitch_flags");
    rd(SWP_COUNT, 32'h1,    "glitch_count");

    // Accept latency and interrupt.
    wr(SWP_MASK, 32'h0000_0001);
    rd(SWP_MASK, 32'h1, "mask_rb");
    sw_raw = 16'h000D;
    n = 0;
    seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      idle(1);
      if (irq) begin
        seen = 1'b1;
        n = i;
      end
    end
    check("accept_seen", {31'd0, seen}, 32'd1);
    check("accept_lat_ok", {31'd0, (n >= 11 && n <= 14)}, 32'd1);
    rd(SWP_VALUE, 32'h000D, "accept_value");
    rd(SWP_FLAGS, 32'h000D, "accept_flags");
    rd(SWP_COUNT, 32'h2,    "accept_count");
    check("accept_irq", {31'd0, irq}, 32'd1);

    // Read of FLAGS together with a write-1-to-clear returns pre-clear value.
    bus_valid = 1'b1;
    rd_en     = 1'b1;
    wr_en     = 1'b1;
    bus_addr  = SWP_BASE_ADDR + {28'd0, SWP_FLAGS, 2'b00};
    wr_data   = 32'h0000_0005;
    exp_q.push_back(32'h000D);
    tag_q.push_back("w1c_preclear");
    idle(1);
    bus_valid = 1'b0;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    check(tag_q.pop_front(), rd_data, exp_q.pop_front());
    rd(SWP_FLAGS, 32'h0008, "w1c_after");
    check("w1c_irq", {31'd0, irq}, 32'd0);

    // Hold a clear of bit 0 every cycle while bit 0 falls: set must win.
    sw_raw    = 16'h000C;
    bus_valid = 1'b1;
    wr_en     = 1'b1;
    bus_addr  = SWP_BASE_ADDR + {28'd0, SWP_FLAGS, 2'b00};
    wr_data   = 32'h0000_0001;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      idle(1);
      if (irq) seen = 1'b1;
    end
    bus_valid = 1'b0;
    wr_en     = 1'b0;
    check("setwins_seen", {31'd0, seen}, 32'd1);
    rd(SWP_FLAGS, 32'h0009, "setwins_flags");
    rd(SWP_VALUE, 32'h000C, "setwins_value");
    rd(SWP_COUNT, 32'h3,    "setwins_count");

    // Counter wrap via backdoor preset.
    force dut.r_count = 16'hFFFF;
    idle(2);
    release dut.r_count;
    rd(SWP_COUNT, 32'hFFFF, "wrap_preset");
    sw_raw = 16'h000D;
    idle(20);
    rd(SWP_VALUE, 32'h000D, "wrap_value");
    rd(SWP_COUNT, 32'h0,    "wrap_count");

    // Reset in the middle of a debounce run.
    sw_raw = 16'h0001;
    idle(7);
    reset = 1'b0;
    #1;
    check("midrst_rd_data", rd_data, 32'd0);
    check("midrst_irq", {31'd0, irq}, 32'd0);
    idle(3);
    reset = 1'b1;
    rd(SWP_VALUE, 32'h0, "midrst_value");
    rd(SWP_FLAGS, 32'h0, "midrst_flags");
    rd(SWP_COUNT, 32'h0, "midrst_count");
    rd(SWP_MASK,  32'h0, "midrst_mask");
    idle(4);
    rd(SWP_VALUE, 32'h0, "midrst_early_value");
    idle(5);
    rd(SWP_VALUE, 32'h0001, "midrst_late_value");
    rd(SWP_FLAGS, 32'h0001, "midrst_late_flags");
    rd(SWP_COUNT, 32'h1,    "midrst_late_count");
    check("midrst_late_irq", {31'd0, irq}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
